// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the flag/stall logic and the branch decoder.
// Holds the 4-bit opcode map, condition flag bit positions inside the
// {Z, V, N} flag vector, and the 3-bit ccc branch condition encodings.
package cpu_pkg;

    typedef enum logic [3:0] {
        OP_ADD    = 4'h0,
        OP_SUB    = 4'h1,
        OP_XOR    = 4'h2,
        OP_RED    = 4'h3,
        OP_SLL    = 4'h4,
        OP_SRA    = 4'h5,
        OP_ROR    = 4'h6,
        OP_PADDSB = 4'h7,
        OP_LW     = 4'h8,
        OP_SW     = 4'h9,
        OP_LLB    = 4'hA,
        OP_LHB    = 4'hB,
        OP_B      = 4'hC,
        OP_BR     = 4'hD,
        OP_PCS    = 4'hE,
        OP_HLT    = 4'hF
    } opcode_t;

    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 0;

    typedef enum logic [2:0] {
        CCC_NEQ  = 3'b000,
        CCC_EQ   = 3'b001,
        CCC_GT   = 3'b010,
        CCC_LT   = 3'b011,
        CCC_GTE  = 3'b100,
        CCC_LTE  = 3'b101,
        CCC_OVFL = 3'b110,
        CCC_UNC  = 3'b111
    } ccc_t;

endpackage

// File: rtl/flag_reg.sv
// Condition flag register with an independent write enable per bit.
// Bits whose enable is low keep their value; synchronous active-high reset
// clears all bits.
//   clk  : system clock
//   rst  : synchronous active-high reset
//   we   : per-bit write enables
//   d    : new flag values
//   q    : registered flags
module flag_reg #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] we,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else begin
            for (int i = 0; i < W; i++) begin
                if (we[i]) q[i] <= d[i];
            end
        end
    end

endmodule

// File: rtl/flag_stall_unit.sv
// Producer side of the branch-decision interface. Updates the {Z, V, N}
// condition flags from the EX-stage ALU result, registers the "ID stalled
// last cycle" indication, and flags a BR in ID whose target register is
// still being produced by EX or by a load in MEM.
//   clk, rst                 : system clock, synchronous active-high reset
//   ex_valid/opcode/result/ovfl : EX-stage instruction and ALU outcome
//   ex_rd, ex_regwrite       : EX-stage destination register write
//   mem_rd, mem_memread      : MEM-stage load destination
//   id_opcode, id_rs         : ID-stage instruction and BR source register
//   stall_en, flush          : stall request / taken-branch flush
//   flags                    : {Z, V, N}
//   has_stalled              : ID was stalled in the previous cycle
//   br_hazard                : BR in ID must wait for its register
module flag_stall_unit
    import cpu_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ex_valid,
    input  logic [3:0]    ex_opcode,
    input  logic [DW-1:0] ex_result,
    input  logic          ex_ovfl,
    input  logic [3:0]    ex_rd,
    input  logic          ex_regwrite,
    input  logic [3:0]    mem_rd,
    input  logic          mem_memread,
    input  logic [3:0]    id_opcode,
    input  logic [3:0]    id_rs,
    input  logic          stall_en,
    input  logic          flush,
    output logic [2:0]    flags,
    output logic          has_stalled,
    output logic          br_hazard
);

    logic [2:0] flag_we;
    logic [2:0] flag_d;

    // Data is always computed; the enables alone decide which bits move.
    always_comb begin
        flag_we         = '0;
        flag_d          = '0;
        flag_d[FLAG_Z]  = (ex_result == '0);
        flag_d[FLAG_V]  = ex_ovfl;
        flag_d[FLAG_N]  = ex_result[DW-1];
        if (ex_valid) begin
            case (opcode_t'(ex_opcode))
                OP_ADD, OP_SUB: flag_we = 3'b111;
                OP_XOR, OP_SLL, OP_SRA, OP_ROR: flag_we[FLAG_Z] = 1'b1;
                default: flag_we = '0;
            endcase
        end
    end

    flag_reg #(.W(3)) u_flag_reg (
        .clk (clk),
        .rst (rst),
        .we  (flag_we),
        .d   (flag_d),
        .q   (flags)
    );

    // Flush kills any stall sequence in progress.
    always_ff @(posedge clk) begin
        if (rst) has_stalled <= 1'b0;
        else     has_stalled <= stall_en & ~flush;
    end

    logic ex_dep;
    logic mem_dep;

    assign ex_dep    = ex_regwrite && (ex_rd == id_rs);
    assign mem_dep   = mem_memread && (mem_rd == id_rs);
    // R0 is hardwired zero, so it can never be pending.
    assign br_hazard = (opcode_t'(id_opcode) == OP_BR) && (id_rs != 4'd0)
                       && (ex_dep || mem_dep);

endmodule

// File: tb/tb_flag_stall_unit.sv
module tb_flag_stall_unit;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          ex_valid;
    logic [3:0]    ex_opcode;
    logic [DW-1:0] ex_result;
    logic          ex_ovfl;
    logic [3:0]    ex_rd;
    logic          ex_regwrite;
    logic [3:0]    mem_rd;
    logic          mem_memread;
    logic [3:0]    id_opcode;
    logic [3:0]    id_rs;
    logic          stall_en;
    logic          flush;
    logic [2:0]    flags;
    logic          has_stalled;
    logic          br_hazard;

    int n_checks = 0;
    int n_errors = 0;
    bit check_en = 1'b0;

    logic [2:0] m_flags = 3'b000;
    logic       m_hs    = 1'b0;

    always #5 clk = ~clk;

    flag_stall_unit #(.DW(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .ex_valid    (ex_valid),
        .ex_opcode   (ex_opcode),
        .ex_result   (ex_result),
        .ex_ovfl     (ex_ovfl),
        .ex_rd       (ex_rd),
        .ex_regwrite (ex_regwrite),
        .mem_rd      (mem_rd),
        .mem_memread (mem_memread),
        .id_opcode   (id_opcode),
        .id_rs       (id_rs),
        .stall_en    (stall_en),
        .flush       (flush),
        .flags       (flags),
        .has_stalled (has_stalled),
        .br_hazard   (br_hazard)
    );

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic model_hazard();
        if (id_opcode != 4'hD || id_rs == 4'd0) return 1'b0;
        return (ex_regwrite && ex_rd == id_rs) || (mem_memread && mem_rd == id_rs);
    endfunction

    // Reference model: flags as named bits, Z at bit 2, V at 1, N at 0.
    always @(posedge clk) begin
        if (rst) begin
            m_flags = 3'b000;
            m_hs    = 1'b0;
        end else begin
            if (ex_valid && (ex_opcode == 4'h0 || ex_opcode == 4'h1)) begin
                m_flags = {(ex_result == 16'h0), ex_ovfl, ex_result[DW-1]};
            end else if (ex_valid && (ex_opcode == 4'h2 || ex_opcode == 4'h4 ||
                                      ex_opcode == 4'h5 || ex_opcode == 4'h6)) begin
                m_flags[2] = (ex_result == 16'h0);
            end
            m_hs = stall_en && !flush;
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("model_flags", {13'b0, flags}, {13'b0, m_flags});
            chk("model_has_stalled", {15'b0, has_stalled}, {15'b0, m_hs});
            chk("model_br_hazard", {15'b0, br_hazard}, {15'b0, model_hazard()});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ex(input logic v, input logic [3:0] op,
                            input logic [15:0] res, input logic ov);
        ex_valid  = v;
        ex_opcode = op;
        ex_result = res;
        ex_ovfl   = ov;
    endtask

    initial begin
        rst = 1'b1;
        drive_ex(1'b0, 4'h0, 16'h0, 1'b0);
        ex_rd = 4'd5; ex_regwrite = 1'b1;
        mem_rd = 4'd0; mem_memread = 1'b0;
        id_opcode = 4'hD; id_rs = 4'd5;
        stall_en = 1'b0; flush = 1'b0;
        #1;
        chk("hazard_in_reset", {15'b0, br_hazard}, 16'd1);
        step();
        step();
        chk("reset_flags", {13'b0, flags}, 16'd0);
        chk("reset_has_stalled", {15'b0, has_stalled}, 16'd0);
        ex_regwrite = 1'b0;
        rst = 1'b0;
        check_en = 1'b1;

        drive_ex(1'b1, 4'h0, 16'h0000, 1'b0); step();
        chk("add_zero", {13'b0, flags}, 16'b100);
        drive_ex(1'b1, 4'h1, 16'h8001, 1'b1); step();
        chk("sub_neg_ovfl", {13'b0, flags}, 16'b011);
        drive_ex(1'b1, 4'h2, 16'h0000, 1'b1); step();
        chk("xor_zero", {13'b0, flags}, 16'b111);
        drive_ex(1'b1, 4'h4, 16'h0004, 1'b0); step();
        chk("sll_nonzero", {13'b0, flags}, 16'b011);
        drive_ex(1'b1, 4'h8, 16'h0000, 1'b0); step();
        chk("lw_hold", {13'b0, flags}, 16'b011);
        drive_ex(1'b1, 4'h7, 16'h0000, 1'b0); step();
        chk("paddsb_hold", {13'b0, flags}, 16'b011);
        drive_ex(1'b0, 4'h0, 16'h0000, 1'b0); step();
        chk("bubble_hold", {13'b0, flags}, 16'b011);

        stall_en = 1'b1; step();
        chk("stall1_on", {15'b0, has_stalled}, 16'd1);
        stall_en = 1'b0; step();
        chk("stall1_off", {15'b0, has_stalled}, 16'd0);
        stall_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall3_on", {15'b0, has_stalled}, 16'd1);
        end
        stall_en = 1'b0; step();
        chk("stall3_off", {15'b0, has_stalled}, 16'd0);

        id_opcode = 4'hD; id_rs = 4'd5;
        ex_rd = 4'd5; ex_regwrite = 1'b1; mem_memread = 1'b0; mem_rd = 4'd0; #1;
        chk("hazard_ex", {15'b0, br_hazard}, 16'd1);
        ex_regwrite = 1'b0; mem_rd = 4'd5; mem_memread = 1'b1; #1;
        chk("hazard_mem", {15'b0, br_hazard}, 16'd1);
        id_rs = 4'd0; mem_rd = 4'd0; ex_rd = 4'd0; ex_regwrite = 1'b1; #1;
        chk("hazard_r0", {15'b0, br_hazard}, 16'd0);
        id_rs = 4'd5; ex_rd = 4'd5; id_opcode = 4'hC; #1;
        chk("hazard_non_br", {15'b0, br_hazard}, 16'd0);
        ex_regwrite = 1'b0; mem_memread = 1'b0; id_opcode = 4'h0;

        stall_en = 1'b1; flush = 1'b1; step();
        chk("stall_flush", {15'b0, has_stalled}, 16'd0);
        flush = 1'b0; stall_en = 1'b0;

        drive_ex(1'b1, 4'h0, 16'h8000, 1'b0); step();
        chk("add_neg", {13'b0, flags}, 16'b001);
        drive_ex(1'b1, 4'h6, 16'h0000, 1'b0); stall_en = 1'b1; step();
        chk("ror_zero", {13'b0, flags}, 16'b101);
        chk("pre_rst_stall", {15'b0, has_stalled}, 16'd1);
        drive_ex(1'b0, 4'h0, 16'h0, 1'b0);
        rst = 1'b1; step();
        chk("rst_mid_flags", {13'b0, flags}, 16'd0);
        chk("rst_mid_stall", {15'b0, has_stalled}, 16'd0);
        rst = 1'b0; stall_en = 1'b0;

        for (int c = 0; c < 3000; c++) begin
            rst         = ($urandom_range(0, 49) == 0);
            ex_valid    = ($urandom_range(0, 3) != 0);
            ex_opcode   = 4'($urandom_range(0, 15));
            ex_result   = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
            ex_ovfl     = 1'($urandom);
            ex_rd       = 4'($urandom_range(0, 3));
            ex_regwrite = 1'($urandom);
            mem_rd      = 4'($urandom_range(0, 3));
            mem_memread = 1'($urandom);
            id_opcode   = ($urandom_range(0, 1) == 0) ? 4'hD : 4'($urandom_range(0, 15));
            id_rs       = 4'($urandom_range(0, 3));
            stall_en    = ($urandom_range(0, 2) != 0);
            flush       = ($urandom_range(0, 4) == 0);
            step();
        end

        rst = 1'b0;
        step();
        check_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/flag_stall_unit.md
# flag_stall_unit

Producer side of the branch-decision interface in the pipelined CPU. Holds the Z/V/N condition flags and updates them from the EX-stage ALU result according to opcode. Generates the registered `has_stalled` indication and the `br_hazard` register-dependency signal consumed by the branch decision logic in ID. Sits between the EX-stage ALU and the ID-stage branch logic; all state lives here.

## Interface
- `DW`, 16: ALU datapath width.
- `clk`  in  1: system clock, all state updates on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `ex_valid`  in  1: EX stage holds a real instruction (0 = bubble).
- `ex_opcode`  in  4: opcode of the EX-stage instruction.
- `ex_result`  in  DW: ALU result of the EX-stage instruction.
- `ex_ovfl`  in  1: ALU signed overflow for ADD/SUB.
- `ex_rd`  in  4: EX-stage destination register.
- `ex_regwrite`  in  1: EX-stage instruction writes `ex_rd`.
- `mem_rd`  in  4: MEM-stage destination register.
- `mem_memread`  in  1: MEM-stage instruction is LW.
- `id_opcode`  in  4: opcode of the ID-stage instruction.
- `id_rs`  in  4: source register of the ID-stage instruction (BR target).
- `stall_en`  in  1: stall request from branch decision logic this cycle.
- `flush`  in  1: pipeline flush (taken branch); kills the stall sequence.
- `flags`  out  3: {Z, V, N}, bit 2 = Z, bit 1 = V, bit 0 = N.
- `has_stalled`  out  1: ID was stalled in the previous cycle.
- `br_hazard`  out  1: BR in ID depends on a not-yet-available register value.

## Operation
- Flag update, only when `ex_valid`=1:
  - ADD (0x0), SUB (0x1): Z = (`ex_result`==0), N = `ex_result`[DW-1], V = `ex_ovfl`.
  - XOR (0x2), SLL (0x4), SRA (0x5), ROR (0x6): Z only; V, N hold.
  - All other opcodes (RED, PADDSB, LW, SW, LLB, LHB, B, BR, PCS, HLT): no flag change.
- Per-bit enables: bits not written hold their value exactly.
- `ex_valid`=0: no flag change regardless of `ex_opcode`.
- `has_stalled` register: next value = `stall_en` & ~`flush`. Holds 1 for as long as ID stays stalled; drops the cycle after `stall_en` deasserts.
- `br_hazard` (combinational): `id_opcode`==0xD AND `id_rs`!=0 AND ((`ex_regwrite` AND `ex_rd`==`id_rs`) OR (`mem_memread` AND `mem_rd`==`id_rs`)). Forced 0 for every non-BR opcode. R0 never hazards.
- Simultaneous `stall_en` and `flush`: flush wins, `has_stalled` goes to 0.
- Flags are never cleared by `flush`; only by `rst`.

## Timing
- Reset: `flags`=3'b000, `has_stalled`=0. `br_hazard` follows inputs combinationally, including during reset.
- Flag latency: flag-setting instruction in EX at cycle t; new `flags` visible at t+1. A conditional branch in ID stalled one cycle (`has_stalled`=1) therefore sees the flags of the immediately preceding instruction.
- `has_stalled` latency: 1 cycle from `stall_en`.
- Reset asserted mid-stall: `has_stalled`=0 and `flags`=0 next cycle; no partial state kept.
- No combinational path from `stall_en` or `flush` to any output.

## Structure
- Shared package `cpu_pkg`: 4-bit opcode constants (ADD..HLT), flag bit indices (FLAG_Z=2, FLAG_V=1, FLAG_N=0), ccc condition encodings.
- Sub-module `flag_reg`: 3-bit register with per-bit write enables and synchronous reset. Top level does opcode decode, hazard compare and `has_stalled` flop.

## Test plan
- Reset then ADD with `ex_result`=0x0000, `ex_ovfl`=0 -> `flags`=3'b100 next cycle. Then SUB with result 0x8001, `ex_ovfl`=1 -> `flags`=3'b011.
- With `flags`=3'b011, XOR result 0x0000 -> 3'b111. Then SLL result 0x0004 -> 3'b011 (V, N held). Then LW, PADDSB, and ADD with `ex_valid`=0 -> unchanged.
- `stall_en` high for 1 cycle -> `has_stalled`=1 exactly one cycle later, then 0. `stall_en` high 3 cycles -> `has_stalled` high 3 cycles, lagging by 1.
- `id_opcode`=0xD, `id_rs`=5:
  - `ex_rd`=5, `ex_regwrite`=1 -> `br_hazard`=1.
  - `mem_rd`=5, `mem_memread`=1 -> 1.
  - `id_rs`=0 -> 0.
  - `id_opcode`=0xC -> 0.
- `stall_en`=1 and `flush`=1 in the same cycle -> `has_stalled`=0 next cycle.
- `rst` asserted while `has_stalled`=1 and `flags`=3'b101 -> both 0 next cycle.
